// File: rtl/bsg_dmc_traffic_gen.sv
// bsg_dmc_traffic_gen: deterministic write/read sweep generator and read-data
// checker that drives a DRAM controller's command, write and read channels.
// Beat data is (seed + word index) replicated across the beat; the checker
// regenerates the expected value from its own count of consumed read beats.
module bsg_dmc_traffic_gen #(
    parameter int data_width_p      = 32,
    parameter int addr_width_p      = 28,
    parameter int burst_len_p       = 2,
    parameter int count_width_p     = 16,
    parameter int max_outstanding_p = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic [1:0]                mode_i,
    input  logic [addr_width_p-1:0]   base_addr_i,
    input  logic [count_width_p-1:0]  num_bursts_i,
    input  logic [31:0]               seed_i,
    output logic                      cmd_v_o,
    output logic                      cmd_write_o,
    output logic [addr_width_p-1:0]   cmd_addr_o,
    input  logic                      cmd_ready_i,
    output logic                      wdata_v_o,
    output logic [data_width_p-1:0]   wdata_o,
    output logic [data_width_p/8-1:0] wmask_o,
    input  logic                      wdata_ready_i,
    input  logic                      rdata_v_i,
    input  logic [data_width_p-1:0]   rdata_i,
    output logic                      rdata_yumi_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic [count_width_p-1:0]  error_count_o,
    output logic                      first_err_v_o,
    output logic [addr_width_p-1:0]   first_err_addr_o,
    output logic [data_width_p-1:0]   first_err_data_o
);

    localparam int BEAT_BYTES  = data_width_p / 8;
    localparam int BURST_BYTES = burst_len_p * BEAT_BYTES;
    localparam int REPL        = data_width_p / 32;
    localparam int BEAT_W      = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
    localparam int OUT_W       = $clog2(max_outstanding_p + 1);

    localparam logic [1:0] MODE_WR         = 2'd0;
    localparam logic [1:0] MODE_RD         = 2'd1;
    localparam logic [1:0] MODE_INTERLEAVE = 2'd3;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_CMD  = 3'd1,
        WR_DATA = 3'd2,
        RD_CMD  = 3'd3,
        DRAIN   = 3'd4,
        DONE    = 3'd5
    } state_e;

    state_e state, state_n;

    // Sweep configuration captured at start
    logic [1:0]               mode;
    logic [addr_width_p-1:0]  base;
    logic [count_width_p-1:0] num_bursts;
    logic [31:0]              seed;

    // Sweep progress
    logic [count_width_p-1:0] burst;
    logic [BEAT_W-1:0]        wr_beat;
    logic [31:0]              rd_word;
    logic [OUT_W-1:0]         outstanding;

    // Checker state
    logic [count_width_p-1:0] error_count;
    logic                     first_err_v;
    logic [addr_width_p-1:0]  first_err_addr;
    logic [data_width_p-1:0]  first_err_data;

    logic start_accept;
    logic last_burst;
    logic wr_last;
    logic rd_last;
    logic rd_room;
    logic cmd_fire;
    logic wr_fire;
    logic rd_cmd_fire;
    logic beat_in_burst;
    logic rd_burst_done;
    logic mismatch;
    logic [31:0] wr_word;
    logic [data_width_p-1:0] rd_expect;
    logic [addr_width_p-1:0] rd_addr;

    // Replicates a 32-bit pattern word across the full beat width.
    function automatic logic [data_width_p-1:0] pattern(input logic [31:0] word);
        return {REPL{word}};
    endfunction

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [count_width_p-1:0] sat_inc(input logic [count_width_p-1:0] val);
        return (val == '1) ? val : val + count_width_p'(1);
    endfunction

    assign start_accept = start_i && ((state == IDLE) || (state == DONE));
    assign last_burst   = (burst == num_bursts - count_width_p'(1));
    assign wr_last      = (wr_beat == BEAT_W'(burst_len_p - 1));
    assign rd_last      = ((rd_word & 32'(burst_len_p - 1)) == 32'(burst_len_p - 1));
    assign rd_room      = (outstanding < OUT_W'(max_outstanding_p));

    assign busy_o       = (state == WR_CMD) || (state == WR_DATA) ||
                          (state == RD_CMD) || (state == DRAIN);
    assign done_o       = (state == DONE);

    assign cmd_fire     = cmd_v_o && cmd_ready_i;
    assign wr_fire      = wdata_v_o && wdata_ready_i;
    assign rd_cmd_fire  = cmd_fire && !cmd_write_o;

    // Burst address wraps silently at the top of the address space.
    assign cmd_addr_o   = base + addr_width_p'(burst) * addr_width_p'(BURST_BYTES);
    assign wr_word      = 32'(burst) * 32'(burst_len_p) + 32'(wr_beat);
    assign wdata_o      = pattern(seed + wr_word);
    assign wmask_o      = '0;

    assign rdata_yumi_o  = rdata_v_i && busy_o;
    assign beat_in_burst = rdata_yumi_o && (outstanding != '0);
    assign rd_burst_done = beat_in_burst && rd_last;
    assign rd_expect     = pattern(seed + rd_word);
    assign rd_addr       = base + addr_width_p'(rd_word) * addr_width_p'(BEAT_BYTES);
    assign mismatch      = (rdata_i != rd_expect);

    assign error_count_o    = error_count;
    assign first_err_v_o    = first_err_v;
    assign first_err_addr_o = first_err_addr;
    assign first_err_data_o = first_err_data;

    // State register
    always_ff @(posedge clk_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_n;
    end

    // Next-state and channel valid decode
    always_comb begin
        state_n     = state;
        cmd_v_o     = 1'b0;
        cmd_write_o = 1'b0;
        wdata_v_o   = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start_i) begin
                    if (num_bursts_i == '0)    state_n = DONE;
                    else if (mode_i == MODE_RD) state_n = RD_CMD;
                    else                        state_n = WR_CMD;
                end
            end
            WR_CMD: begin
                cmd_v_o     = 1'b1;
                cmd_write_o = 1'b1;
                if (cmd_ready_i) state_n = WR_DATA;
            end
            WR_DATA: begin
                wdata_v_o = 1'b1;
                if (wdata_ready_i && wr_last) begin
                    if (mode == MODE_INTERLEAVE) state_n = RD_CMD;
                    else if (!last_burst)        state_n = WR_CMD;
                    else if (mode == MODE_WR)    state_n = DONE;
                    else                         state_n = RD_CMD;
                end
            end
            RD_CMD: begin
                // Withhold the read command while the in-flight limit is reached.
                cmd_v_o = rd_room;
                if (rd_room && cmd_ready_i) begin
                    if (last_burst)                   state_n = DRAIN;
                    else if (mode == MODE_INTERLEAVE) state_n = WR_CMD;
                end
            end
            DRAIN: begin
                if (outstanding == '0) state_n = DONE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Configuration latch and command/write-beat progress counters
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            mode       <= '0;
            base       <= '0;
            num_bursts <= '0;
            seed       <= '0;
            burst      <= '0;
            wr_beat    <= '0;
        end else if (start_accept) begin
            mode       <= mode_i;
            base       <= base_addr_i;
            num_bursts <= num_bursts_i;
            seed       <= seed_i;
            burst      <= '0;
            wr_beat    <= '0;
        end else begin
            if (wr_fire) begin
                wr_beat <= wr_last ? '0 : wr_beat + BEAT_W'(1);
                // Interleaved mode reads back the same burst before advancing.
                if (wr_last && (mode != MODE_INTERLEAVE)) begin
                    burst <= last_burst ? '0 : burst + count_width_p'(1);
                end
            end
            if (rd_cmd_fire) begin
                burst <= burst + count_width_p'(1);
            end
        end
    end

    // Read commands in flight: up on command accept, down on last beat of a burst
    always_ff @(posedge clk_i) begin
        if (reset_i || start_accept) begin
            outstanding <= '0;
        end else begin
            case ({rd_cmd_fire, rd_burst_done})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Read-data checker: compare each consumed beat with the regenerated pattern
    always_ff @(posedge clk_i) begin
        if (reset_i || start_accept) begin
            rd_word        <= '0;
            error_count    <= '0;
            first_err_v    <= 1'b0;
            first_err_addr <= '0;
            first_err_data <= '0;
        end else if (rdata_yumi_o) begin
            if (outstanding == '0) begin
                // Stray beat with no read pending: counted, never captured.
                error_count <= sat_inc(error_count);
            end else begin
                rd_word <= rd_word + 32'd1;
                if (mismatch) begin
                    error_count <= sat_inc(error_count);
                    if (!first_err_v) begin
                        first_err_v    <= 1'b1;
                        first_err_addr <= rd_addr;
                        first_err_data <= rdata_i;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_bsg_dmc_traffic_gen.sv
// Bench for bsg_dmc_traffic_gen: a table of sweeps run against a behavioural
// memory, with expected commands and write beats queued at start and popped
// as the DUT issues them.
module tb_bsg_dmc_traffic_gen;

    localparam int DW = 32;
    localparam int AW = 28;
    localparam int BL = 2;
    localparam int CW = 16;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic          start_i = 1'b0;
    logic [1:0]    mode_i = '0;
    logic [AW-1:0] base_addr_i = '0;
    logic [CW-1:0] num_bursts_i = '0;
    logic [31:0]   seed_i = '0;
    logic          cmd_v_o, cmd_write_o;
    logic [AW-1:0] cmd_addr_o;
    logic          cmd_ready_i = 1'b0;
    logic          wdata_v_o;
    logic [DW-1:0] wdata_o;
    logic [DW/8-1:0] wmask_o;
    logic          wdata_ready_i = 1'b0;
    logic          rdata_v_i = 1'b0;
    logic [DW-1:0] rdata_i = '0;
    logic          rdata_yumi_o, busy_o, done_o;
    logic [CW-1:0] error_count_o;
    logic          first_err_v_o;
    logic [AW-1:0] first_err_addr_o;
    logic [DW-1:0] first_err_data_o;

    bsg_dmc_traffic_gen #(
        .data_width_p(DW), .addr_width_p(AW), .burst_len_p(BL),
        .count_width_p(CW), .max_outstanding_p(MO)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .mode_i(mode_i),
        .base_addr_i(base_addr_i), .num_bursts_i(num_bursts_i), .seed_i(seed_i),
        .cmd_v_o(cmd_v_o), .cmd_write_o(cmd_write_o), .cmd_addr_o(cmd_addr_o),
        .cmd_ready_i(cmd_ready_i), .wdata_v_o(wdata_v_o), .wdata_o(wdata_o),
        .wmask_o(wmask_o), .wdata_ready_i(wdata_ready_i), .rdata_v_i(rdata_v_i),
        .rdata_i(rdata_i), .rdata_yumi_o(rdata_yumi_o), .busy_o(busy_o),
        .done_o(done_o), .error_count_o(error_count_o), .first_err_v_o(first_err_v_o),
        .first_err_addr_o(first_err_addr_o), .first_err_data_o(first_err_data_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    mode;
        logic [AW-1:0] base;
        logic [CW-1:0] nb;
        logic [31:0]   seed;
        bit            corrupt;
        logic [AW-1:0] corrupt_addr;
        int            delay;
        bit            rand_rdy;
        bit            poke;
        logic [CW-1:0] exp_err;
        bit            exp_fv;
        logic [AW-1:0] exp_faddr;
        logic [31:0]   exp_fdata;
    } vec_t;

    typedef struct packed {
        logic          w;
        logic [AW-1:0] a;
    } cmd_t;

    typedef struct {
        logic [AW-1:0] a;
        int            due;
    } rd_t;

    vec_t tab[10];
    vec_t cur;

    cmd_t        cmdq[$];
    logic [31:0] wdq[$];
    rd_t         rdq[$];
    logic [31:0] mem [logic [AW-1:0]];

    int nvec = 0;
    int nfail = 0;
    int cyc = 0;
    int inflight = 0;
    int max_inf = 0;
    int rd_beat = 0;
    int rd_total = 0;
    int stab_viol = 0;
    int thr_viol = 0;
    logic [AW-1:0] wrp = '0;

    // Handshakes seen just before the coming edge, with the values offered.
    bit            cmd_f = 0, wd_f = 0, rd_f = 0;
    logic          s_cmd_w = 1'b0;
    logic [AW-1:0] s_cmd_a = '0;
    logic [DW-1:0] s_wd = '0;
    bit            cmd_hold = 0, wd_hold = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] memrd(input logic [AW-1:0] a);
        logic [31:0] d;
        d = mem.exists(a) ? mem[a] : 32'h0;
        if (cur.corrupt && (a == cur.corrupt_addr)) d = d ^ 32'h0F0F0F0F;
        return d;
    endfunction

    // One clock: account for the handshakes at this edge, check, drive next.
    task automatic step();
        cmd_t e;
        logic [31:0] ew;
        @(posedge clk);
        cyc++;
        #1;
        if (!reset_i) begin
            if (cmd_f) begin
                if (cmdq.size() == 0) begin
                    chk("unexpected_cmd", {s_cmd_w, s_cmd_a}, 0);
                end else begin
                    e = cmdq.pop_front();
                    chk("cmd_write", s_cmd_w, e.w);
                    chk("cmd_addr", s_cmd_a, e.a);
                end
                if (s_cmd_w) wrp = s_cmd_a;
                else begin
                    rdq.push_back('{s_cmd_a, cyc + cur.delay});
                    inflight++;
                end
            end
            if (wd_f) begin
                if (wdq.size() == 0) begin
                    chk("unexpected_wdata", s_wd, 0);
                end else begin
                    ew = wdq.pop_front();
                    chk("wdata", s_wd, ew);
                end
                mem[wrp] = s_wd[31:0];
                wrp = wrp + AW'(4);
            end
            if (rd_f) begin
                rd_total++;
                rd_beat++;
                if (rd_beat == BL) begin
                    rd_beat = 0;
                    void'(rdq.pop_front());
                    inflight--;
                end
            end
            if (cmd_hold && (!cmd_v_o || cmd_write_o !== s_cmd_w || cmd_addr_o !== s_cmd_a))
                stab_viol++;
            if (wd_hold && (!wdata_v_o || wdata_o !== s_wd))
                stab_viol++;
            if (inflight >= MO && cmd_v_o && !cmd_write_o) thr_viol++;
            if (inflight > max_inf) max_inf = inflight;
        end
        cmd_ready_i   = cur.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        wdata_ready_i = cur.rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (rdq.size() > 0 && cyc >= rdq[0].due) begin
            rdata_v_i = 1'b1;
            rdata_i   = memrd(rdq[0].a + AW'(rd_beat * 4));
        end else begin
            rdata_v_i = 1'b0;
            rdata_i   = '0;
        end
        #1;
        cmd_f    = cmd_v_o && cmd_ready_i;
        wd_f     = wdata_v_o && wdata_ready_i;
        rd_f     = rdata_v_i && rdata_yumi_o;
        s_cmd_w  = cmd_write_o;
        s_cmd_a  = cmd_addr_o;
        s_wd     = wdata_o;
        cmd_hold = cmd_v_o && !cmd_ready_i;
        wd_hold  = wdata_v_o && !wdata_ready_i;
    endtask

    task automatic build_exp(input vec_t v);
        logic [AW-1:0] a;
        cmdq.delete();
        wdq.delete();
        for (int b = 0; b < int'(v.nb); b++) begin
            a = v.base + AW'(b * BL * 4);
            if (v.mode != 2'd1) begin
                cmdq.push_back({1'b1, a});
                for (int k = 0; k < BL; k++) wdq.push_back(v.seed + 32'(b * BL + k));
            end
            if (v.mode == 2'd1 || v.mode == 2'd3) cmdq.push_back({1'b0, a});
        end
        if (v.mode == 2'd2) begin
            for (int b = 0; b < int'(v.nb); b++) cmdq.push_back({1'b0, v.base + AW'(b * BL * 4)});
        end
    endtask

    task automatic start_sweep(input vec_t v);
        cur = v;
        build_exp(v);
        rd_total = 0; stab_viol = 0; thr_viol = 0; max_inf = 0;
        mode_i = v.mode; base_addr_i = v.base; num_bursts_i = v.nb; seed_i = v.seed;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        chk("busy_after_start", busy_o, (v.nb != 0));
        chk("done_after_start", done_o, (v.nb == 0));
    endtask

    task automatic finish_sweep(input vec_t v);
        int n;
        n = 0;
        while (!done_o && n < 6000) begin
            if (v.poke && n == 5) begin
                start_i = 1'b1; mode_i = 2'd1; base_addr_i = '0; num_bursts_i = 16'd1; seed_i = '0;
            end else begin
                start_i = 1'b0;
            end
            step();
            n++;
        end
        start_i = 1'b0;
        chk("sweep_done", done_o, 1);
        chk("busy_at_done", busy_o, 0);
        chk("error_count", error_count_o, v.exp_err);
        chk("first_err_v", first_err_v_o, v.exp_fv);
        chk("first_err_addr", first_err_addr_o, v.exp_faddr);
        chk("first_err_data", first_err_data_o, v.exp_fdata);
        chk("cmds_left", cmdq.size(), 0);
        chk("wbeats_left", wdq.size(), 0);
        chk("read_beats", rd_total, (v.mode == 2'd0) ? 0 : int'(v.nb) * BL);
        chk("stall_stability", stab_viol, 0);
        chk("throttle", thr_viol, 0);
        chk("max_inflight_ok", (max_inf <= MO), 1);
        if (v.delay >= 20) chk("inflight_reached_max", max_inf, MO);
    endtask

    initial begin
        //          mode  base          nb     seed           cor  caddr       dly rnd poke err    fv   faddr      fdata
        tab[0] = '{2'd2, 28'h100,     16'd4,  32'h1000,     0, 28'h0,     2,  0,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[1] = '{2'd2, 28'h100,     16'd4,  32'h1000,     1, 28'h114,   2,  0,  0, 16'd1,  1, 28'h114, 32'h0F0F1F0A};
        tab[2] = '{2'd0, 28'h200,     16'd10, 32'h2000,     0, 28'h0,     2,  0,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[3] = '{2'd1, 28'h200,     16'd10, 32'h2000,     0, 28'h0,     20, 0,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[4] = '{2'd1, 28'h200,     16'd10, 32'h2001,     0, 28'h0,     1,  0,  0, 16'd20, 1, 28'h200, 32'h2000};
        tab[5] = '{2'd3, 28'h400,     16'd3,  32'hABCD0000, 0, 28'h0,     3,  1,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[6] = '{2'd2, 28'hFFFFFF8, 16'd2,  32'h55,       0, 28'h0,     2,  0,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[7] = '{2'd2, 28'h600,     16'd2,  32'hFFFFFFFE, 0, 28'h0,     4,  1,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[8] = '{2'd0, 28'h0,       16'd0,  32'h0,        0, 28'h0,     2,  0,  0, 16'd0,  0, 28'h0,   32'h0};
        tab[9] = '{2'd0, 28'h800,     16'd4,  32'h3000,     0, 28'h0,     2,  1,  1, 16'd0,  0, 28'h0,   32'h0};
        cur = tab[0];

        reset_i = 1'b1;
        step();
        step();
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cmd_v", cmd_v_o, 0);
        chk("rst_wdata_v", wdata_v_o, 0);
        chk("rst_err_count", error_count_o, 0);
        chk("rst_first_err_v", first_err_v_o, 0);
        reset_i = 1'b0;
        step();

        for (int i = 0; i < 10; i++) begin
            start_sweep(tab[i]);
            finish_sweep(tab[i]);
            chk("wmask", wmask_o, 0);
        end

        // Reset in the middle of a write burst, then a clean rerun.
        start_sweep('{2'd0, 28'h900, 16'd4, 32'h4000, 0, 28'h0, 2, 0, 0, 16'd0, 0, 28'h0, 32'h0});
        begin
            int n;
            n = 0;
            while (!wdata_v_o && n < 100) begin step(); n++; end
        end
        chk("reached_wr_data", wdata_v_o, 1);
        reset_i = 1'b1;
        step();
        chk("mid_rst_cmd_v", cmd_v_o, 0);
        chk("mid_rst_cmd_write", cmd_write_o, 0);
        chk("mid_rst_cmd_addr", cmd_addr_o, 0);
        chk("mid_rst_wdata_v", wdata_v_o, 0);
        chk("mid_rst_wdata", wdata_o, 0);
        chk("mid_rst_yumi", rdata_yumi_o, 0);
        chk("mid_rst_busy", busy_o, 0);
        chk("mid_rst_done", done_o, 0);
        chk("mid_rst_err", error_count_o, 0);
        chk("mid_rst_fev", first_err_v_o, 0);
        chk("mid_rst_fea", first_err_addr_o, 0);
        chk("mid_rst_fed", first_err_data_o, 0);
        reset_i = 1'b0;
        cmdq.delete(); wdq.delete(); rdq.delete();
        rd_beat = 0; inflight = 0;
        step();
        start_sweep(tab[0]);
        finish_sweep(tab[0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/bsg_dmc_traffic_gen.md
Name: bsg_dmc_traffic_gen

Overview:
Synthesisable on-chip traffic generator and checker for DRAM controller bring-up. It generates a deterministic write/read sweep over a programmable address window and regenerates the expected read data locally, so no off-chip trace source is needed. It drives the DMC application command, write-data and read-data channels directly and reports pass/fail status plus the first failing location. It sits beside the DMC in the test harness, under control of a config block or debug registers.

Parameters:
data_width_p, 32, DMC data beat width; must be a multiple of 32.
addr_width_p, 28, DMC byte address width.
burst_len_p, 2, data beats per command; power of two, ≥1.
count_width_p, 16, width of the burst-count and error-count registers.
max_outstanding_p, 4, maximum read commands in flight.

Ports:
clk_i  in  1  core clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  start pulse; sampled only in IDLE or DONE
mode_i  in  2  0=write-only, 1=read-check-only, 2=write-all-then-read-all, 3=interleaved write/read per burst
base_addr_i  in  addr_width_p  start byte address
num_bursts_i  in  count_width_p  number of bursts to sweep
seed_i  in  32  data pattern seed
cmd_v_o  out  1  command valid
cmd_write_o  out  1  1=write, 0=read
cmd_addr_o  out  addr_width_p  command byte address
cmd_ready_i  in  1  DMC accepts command
wdata_v_o  out  1  write beat valid
wdata_o  out  data_width_p  write beat
wmask_o  out  data_width_p/8  byte mask; always 0 (all bytes written)
wdata_ready_i  in  1  DMC accepts beat
rdata_v_i  in  1  read beat valid
rdata_i  in  data_width_p  read beat
rdata_yumi_o  out  1  read beat consumed
busy_o  out  1  sweep in progress
done_o  out  1  sweep complete; held until the next accepted start or reset
error_count_o  out  count_width_p  mismatched beats, saturating
first_err_v_o  out  1  first_err_* fields valid
first_err_addr_o  out  addr_width_p  byte address of the first mismatched beat
first_err_data_o  out  data_width_p  received data of the first mismatched beat

Behaviour:
- Interface: one clock, clk_i; reset_i is synchronous and active-high.
- Reset: FSM goes to IDLE. All valid outputs, busy_o, done_o, first_err_v_o, error_count_o and all counters clear to 0. Reset asserted mid-sweep abandons the sweep immediately; read beats still in flight from the DMC after reset are not the block's responsibility.
- Start: start_i in IDLE or DONE latches mode_i, base_addr_i, num_bursts_i and seed_i, clears the error state and done_o, and sets busy_o on the next cycle. start_i while busy_o=1 is ignored. num_bursts_i=0 goes to DONE one cycle after start, with no traffic.
- Addressing: burst b has address base + b*burst_len_p*(data_width_p/8), mod 2^addr_width_p (wraps silently). Beat k of burst b has word index w = b*burst_len_p + k.
- Data pattern: each beat is the 32-bit value (seed + w) mod 2^32, replicated data_width_p/32 times. The checker regenerates the same value from its own read-beat counter.
- FSM states: IDLE, WR_CMD, WR_DATA, RD_CMD, DRAIN, DONE.
- WR_CMD: hold cmd_v_o=1, cmd_write_o=1 until cmd_ready_i, then go to WR_DATA.
- WR_DATA: send burst_len_p beats, each advancing on wdata_v_o & wdata_ready_i. After the last beat:
  - mode 3: go to RD_CMD for the same burst.
  - modes 0 and 2: go to the next WR_CMD, or after the final burst: mode 0 → DONE, mode 2 → RD_CMD with the burst index reset to 0.
- RD_CMD: cmd_v_o=1 with cmd_write_o=0 only while outstanding < max_outstanding_p; otherwise cmd_v_o=0 and the FSM stalls.
- After a read command is accepted:
  - mode 3: go back to WR_CMD for the next burst.
  - modes 1 and 2: issue the next read.
  - after the final burst, all read modes go to DRAIN.
- DRAIN: wait until outstanding=0, then go to DONE.
- Outstanding counter: +1 on an accepted read command, −1 when the last beat of a read burst is consumed; both in the same cycle → unchanged.
- Read channel: rdata_yumi_o = rdata_v_i whenever busy_o=1. Reads are assumed in-order.
  - Any mismatch → error_count_o +1, saturating at all-ones.
  - The first mismatch sets first_err_v_o and captures the beat's address and data.
  - A beat arriving with outstanding=0 counts as one error and is not captured.
- Command and write outputs hold stable while valid and not accepted.
- DONE: busy_o=0, done_o=1; outputs hold until the next start_i.

Test Plan:
- Mode 2, base=0x100, num_bursts=4, seed=0x1000, ideal memory model → 4 write commands at 0x100/0x108/0x110/0x118, beats 0x1000..0x1007, then 4 reads; done_o=1, error_count_o=0.
- Same as above with the memory model corrupting word index 5 → error_count_o=1, first_err_addr_o=0x114, first_err_data_o equal to the corrupted value.
- Mode 1, num_bursts=10, memory delays reads 20 cycles, max_outstanding_p=4 → never more than 4 reads in flight; cmd_v_o=0 while outstanding=4; done_o only after the 20th beat.
- Mode 3, num_bursts=3, with cmd_ready_i and wdata_ready_i toggled randomly → command sequence is W,R,W,R,W,R, outputs stable while stalled, error_count_o=0.
- num_bursts=0 → done_o high one cycle after start with no cmd_v_o; start_i pulsed mid-sweep is ignored; reset_i asserted mid-WR_DATA → all outputs 0 next cycle, and a fresh start runs cleanly.
- base=2^28−8, num_bursts=2 → second burst address wraps to 0x0.
